// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier:
// FSM state encoding, accumulator width and the shift/saturate step.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Wide enough for any legal accumulator; callers sign-extend into it.
  localparam int SAT_ACC_W = 128;
  localparam int SAT_VAL_W = 64;

  typedef struct packed {
    logic signed [SAT_VAL_W-1:0] value;
    logic                        ovf;
  } sat_t;

  function automatic int acc_width(input int bit_w, input int depth);
    return 2 * bit_w + $clog2(depth);
  endfunction

  // Arithmetic shift right by frac_w, then clamp to a signed bit_w range.
  function automatic sat_t sat_q(input logic signed [SAT_ACC_W-1:0] acc,
                                 input int frac_w, input int bit_w);
    logic signed [SAT_ACC_W-1:0] sh;
    logic signed [SAT_ACC_W-1:0] max_v;
    logic signed [SAT_ACC_W-1:0] min_v;
    sat_t r;
    sh    = acc >>> frac_w;
    max_v = (128'sd1 <<< (bit_w - 1)) - 128'sd1;
    min_v = -(128'sd1 <<< (bit_w - 1));
    r.ovf = 1'b0;
    if (sh > max_v) begin
      r.value = max_v[SAT_VAL_W-1:0];
      r.ovf   = 1'b1;
    end else if (sh < min_v) begin
      r.value = min_v[SAT_VAL_W-1:0];
      r.ovf   = 1'b1;
    end else begin
      r.value = sh[SAT_VAL_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/matmul_seq_mac_lane.sv
// One multiply-accumulate lane: signed BIT_WIDTH x BIT_WIDTH product added
// into an ACC_W accumulator with synchronous clear and enable.
module mac_lane #(
  parameter int BIT_WIDTH = 32,
  parameter int ACC_W     = 67
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [BIT_WIDTH-1:0]    a,
  input  logic [BIT_WIDTH-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*BIT_WIDTH-1:0] prod;

  assign prod = $signed(a) * $signed(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Resource-shared signed Q-format matrix multiplier using NUM_MAC lanes.
// Define MATMUL_SEQ_RELU_EN to apply ReLU to every written element.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int FRACTION_WIDTH = 15,
  parameter int BIT_WIDTH      = 32,
  parameter int d1             = 5,
  parameter int d2             = 5,
  parameter int d3             = 5,
  parameter int NUM_MAC        = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] matA   [d1][d2],
  input  logic [BIT_WIDTH-1:0] matB   [d2][d3],
  output logic [BIT_WIDTH-1:0] result [d1][d3],
  output logic                 busy,
  output logic                 done,
  output logic                 sat_flag
);

  localparam int N_OUT = d1 * d3;
  localparam int G     = (N_OUT + NUM_MAC - 1) / NUM_MAC;
  localparam int ACC_W = acc_width(BIT_WIDTH, d2);
  localparam int D1_W  = (d1 > 1) ? $clog2(d1) : 1;
  localparam int D2_W  = (d2 > 1) ? $clog2(d2) : 1;
  localparam int D3_W  = (d3 > 1) ? $clog2(d3) : 1;
  localparam int G_W   = (G > 1) ? $clog2(G) : 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_MAC   = ST_MAC;
  localparam logic [1:0] S_WRITE = ST_WRITE;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]           state_reg;
  logic [D2_W-1:0]      k_reg;
  logic [G_W-1:0]       g_reg;
  logic [BIT_WIDTH-1:0] a_reg [d1][d2];
  logic [BIT_WIDTH-1:0] b_reg [d2][d3];

  logic                    lane_act [NUM_MAC];
  logic [D1_W-1:0]         lane_i   [NUM_MAC];
  logic [D3_W-1:0]         lane_j   [NUM_MAC];
  logic signed [ACC_W-1:0] lane_acc [NUM_MAC];
  logic [BIT_WIDTH-1:0]    lane_val [NUM_MAC];
  logic                    lane_ovf [NUM_MAC];

  logic accept;
  logic lane_clr;
  logic mac_en;
  logic wr_ovf;

  assign accept   = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign lane_clr = accept || (state_reg == S_WRITE);
  assign mac_en   = (state_reg == S_MAC);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MAC; gi++) begin : g_lane
      // Lane gi owns output n = g*NUM_MAC + gi; lanes past the end sit idle.
      always_comb begin
        int n;
        n = int'(g_reg) * NUM_MAC + gi;
        lane_act[gi] = (n < N_OUT);
        lane_i[gi]   = lane_act[gi] ? D1_W'(n / d3) : '0;
        lane_j[gi]   = lane_act[gi] ? D3_W'(n % d3) : '0;
      end

      mac_lane #(
        .BIT_WIDTH(BIT_WIDTH),
        .ACC_W    (ACC_W)
      ) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (lane_clr),
        .en   (mac_en && lane_act[gi]),
        .a    (a_reg[lane_i[gi]][k_reg]),
        .b    (b_reg[k_reg][lane_j[gi]]),
        .acc  (lane_acc[gi])
      );

      always_comb begin
        sat_t s;
        s = sat_q(SAT_ACC_W'(lane_acc[gi]), FRACTION_WIDTH, BIT_WIDTH);
`ifdef MATMUL_SEQ_RELU_EN
        if (s.value[SAT_VAL_W-1]) begin
          lane_val[gi] = '0;
          lane_ovf[gi] = 1'b0;
        end else begin
          lane_val[gi] = s.value[BIT_WIDTH-1:0];
          lane_ovf[gi] = s.ovf;
        end
`else
        lane_val[gi] = s.value[BIT_WIDTH-1:0];
        lane_ovf[gi] = s.ovf;
`endif
      end
    end
  endgenerate

  always_comb begin
    wr_ovf = 1'b0;
    for (int l = 0; l < NUM_MAC; l++) begin
      if (lane_act[l] && lane_ovf[l]) wr_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      k_reg     <= '0;
      g_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
      for (int r = 0; r < d1; r++) for (int c = 0; c < d2; c++) a_reg[r][c] <= '0;
      for (int r = 0; r < d2; r++) for (int c = 0; c < d3; c++) b_reg[r][c] <= '0;
      for (int r = 0; r < d1; r++) for (int c = 0; c < d3; c++) result[r][c] <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_reg     <= matA;
            b_reg     <= matB;
            k_reg     <= '0;
            g_reg     <= '0;
            sat_flag  <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state_reg <= S_MAC;
          end
        end
        S_MAC: begin
          if (k_reg == D2_W'(d2 - 1)) begin
            k_reg     <= '0;
            state_reg <= S_WRITE;
          end else begin
            k_reg <= k_reg + D2_W'(1);
          end
        end
        S_WRITE: begin
          for (int l = 0; l < NUM_MAC; l++) begin
            if (lane_act[l]) result[lane_i[l]][lane_j[l]] <= lane_val[l];
          end
          if (wr_ovf) sat_flag <= 1'b1;
          if (g_reg == G_W'(G - 1)) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            g_reg     <= g_reg + G_W'(1);
            state_reg <= S_MAC;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: NUM_MAC=2 and NUM_MAC=3 instances share
// stimulus; a scoreboard queue holds expected results per accepted start.
module tb_matmul_seq;

  localparam int FW = 8;
  localparam int BW = 16;
  localparam int D1 = 2;
  localparam int D2 = 3;
  localparam int D3 = 2;

  typedef struct packed {
    logic                       sat;
    logic [D1*D3-1:0][BW-1:0]   r;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [BW-1:0] mat_a [D1][D2];
  logic [BW-1:0] mat_b [D2][D3];
  logic [BW-1:0] res2  [D1][D3];
  logic [BW-1:0] res3  [D1][D3];
  logic          busy2, done2, sat2;
  logic          busy3, done3, sat3;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  matmul_seq #(.FRACTION_WIDTH(FW), .BIT_WIDTH(BW), .d1(D1), .d2(D2), .d3(D3), .NUM_MAC(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .matA(mat_a), .matB(mat_b),
    .result(res2), .busy(busy2), .done(done2), .sat_flag(sat2)
  );

  matmul_seq #(.FRACTION_WIDTH(FW), .BIT_WIDTH(BW), .d1(D1), .d2(D2), .d3(D3), .NUM_MAC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .matA(mat_a), .matB(mat_b),
    .result(res3), .busy(busy3), .done(done3), .sat_flag(sat3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, arithmetic shift, clamp, optional ReLU.
  function automatic exp_t model();
    exp_t   e;
    longint acc;
    e = '0;
    for (int i = 0; i < D1; i++) begin
      for (int j = 0; j < D3; j++) begin
        acc = 0;
        for (int k = 0; k < D2; k++)
          acc += longint'($signed(mat_a[i][k])) * longint'($signed(mat_b[k][j]));
        acc = acc >>> FW;
        if (acc > 32767) begin
          acc = 32767;
          e.sat = 1'b1;
        end else if (acc < -32768) begin
          acc = -32768;
`ifndef MATMUL_SEQ_RELU_EN
          e.sat = 1'b1;
`endif
        end
`ifdef MATMUL_SEQ_RELU_EN
        if (acc < 0) acc = 0;
`endif
        e.r[i*D3+j] = acc[BW-1:0];
      end
    end
    return e;
  endfunction

  task automatic fill(input logic [BW-1:0] av, input logic [BW-1:0] bv);
    for (int i = 0; i < D1; i++) for (int k = 0; k < D2; k++) mat_a[i][k] = av;
    for (int k = 0; k < D2; k++) for (int j = 0; j < D3; j++) mat_b[k][j] = bv;
  endtask

  task automatic load_basic();
    for (int i = 0; i < D1; i++)
      for (int k = 0; k < D2; k++) mat_a[i][k] = BW'((i * D2 + k + 1) * 256);
    mat_b[0][0] = 16'd256; mat_b[0][1] = 16'd0;
    mat_b[1][0] = 16'd0;   mat_b[1][1] = 16'd256;
    mat_b[2][0] = 16'd256; mat_b[2][1] = 16'd256;
  endtask

  // Drives start across one edge (edge 0), returning #1 after it.
  task automatic pulse_start(input bit push);
    @(negedge clk);
    start = 1'b1;
    if (push) sb.push_back(model());
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (!done2 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic check_run(input string tag, input int cyc);
    exp_t e;
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_done3"}, done3, 1);
    check({tag, "_busy2"}, busy2, 0);
    check({tag, "_busy3"}, busy3, 0);
    check({tag, "_sb_size"}, sb.size(), 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int i = 0; i < D1; i++) begin
      for (int j = 0; j < D3; j++) begin
        check($sformatf("%s_res2[%0d][%0d]", tag, i, j), res2[i][j], e.r[i*D3+j]);
        check($sformatf("%s_res3[%0d][%0d]", tag, i, j), res3[i][j], e.r[i*D3+j]);
      end
    end
    check({tag, "_sat2"}, sat2, e.sat);
    check({tag, "_sat3"}, sat3, e.sat);
    $display("run %s: latency=%0d sat=%0d r00=%0h r11=%0h", tag, cyc, sat2, res2[0][0], res2[1][1]);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < D1; i++) begin
      for (int j = 0; j < D3; j++) begin
        check($sformatf("%s_res2[%0d][%0d]", tag, i, j), res2[i][j], 0);
        check($sformatf("%s_res3[%0d][%0d]", tag, i, j), res3[i][j], 0);
      end
    end
    check({tag, "_busy"}, {busy2, busy3}, 0);
    check({tag, "_done"}, {done2, done3}, 0);
    check({tag, "_sat"}, {sat2, sat3}, 0);
    $display("reset check %s", tag);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    fill('0, '0);
    repeat (2) @(posedge clk);
    #1 check_zero("por");
    @(negedge clk) rst_n = 1'b1;

    // Basic product, also against hand-computed constants
    load_basic();
    pulse_start(1);
    wait_done(0, cyc);
    check("basic_const00", res2[0][0], 16'd1024);
    check("basic_const01", res2[0][1], 16'd1280);
    check("basic_const10", res2[1][0], 16'd2560);
    check("basic_const11", res2[1][1], 16'd2816);
    check_run("basic", cyc);

    // Positive saturation
    fill(16'h7FFF, 16'h7FFF);
    pulse_start(1);
    wait_done(0, cyc);
    check_run("sat_pos", cyc);

    // Negative values; sticky flag must clear on the new start
    fill(16'hFF00, 16'h0100);
    pulse_start(1);
    wait_done(0, cyc);
`ifndef MATMUL_SEQ_RELU_EN
    check("neg_const00", res2[0][0], 16'hFD00);
`else
    check("relu_const00", res2[0][0], 16'h0000);
`endif
    check_run("neg", cyc);

    // start during MAC ignored; input changes after start ignored
    load_basic();
    pulse_start(1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    fill(16'h7FFF, 16'h7FFF);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("ign_busy", busy2, 1);
    wait_done(3, cyc);
    check_run("ignored_start", cyc);

    // Restart straight from DONE
    fill(16'h0200, 16'h0080);
    pulse_start(1);
    check("restart_done_low", done2, 0);
    check("restart_busy_high", busy2, 1);
    wait_done(0, cyc);
    check_run("restart", cyc);

    // Asynchronous reset mid-run
    load_basic();
    pulse_start(1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1 check_zero("midrun");
    void'(sb.pop_back());
    @(negedge clk) rst_n = 1'b1;

    fill(16'h0180, 16'hFF80);
    pulse_start(1);
    wait_done(0, cyc);
    check_run("post_reset", cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Sequential, resource-shared signed fixed-point matrix multiplier: result = matA (d1 x d2) x matB (d2 x d3).
- Uses NUM_MAC multiply-accumulate lanes, time-multiplexed over the d1*d3 outputs, instead of one dot-product unit per output element.
- Adds a start/busy/done handshake, wide accumulation, saturation and a sticky overflow flag.
- Building block for dense/FC layers in the inference datapath where a full dot-product array does not fit the FPGA.

Parameters:
- FRACTION_WIDTH, 15, fractional bits of the signed Q format (inputs and outputs).
- BIT_WIDTH, 32, width of each matrix element, two's complement.
- d1, 5, rows of A.
- d2, 5, columns of A / rows of B.
- d3, 5, columns of B.
- NUM_MAC, 5, parallel MAC lanes; legal range 1..d1*d3.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE or DONE.
- matA  in  [BIT_WIDTH-1:0] x [d1][d2]  operand A; captured on accepted start.
- matB  in  [BIT_WIDTH-1:0] x [d2][d3]  operand B; captured on accepted start.
- result  out  [BIT_WIDTH-1:0] x [d1][d3]  registered product; valid while done=1.
- busy  out  1  high from accepted start until the last write.
- done  out  1  level; high from completion until the next accepted start.
- sat_flag  out  1  sticky per run; set if any output was saturated or clamped.

Behaviour:
- Reset (async assert): state IDLE; all internal registers zero.
  - Output reset values: result all zero, busy=0, done=0, sat_flag=0.
  - Reset mid-operation aborts the run; no partial-run state survives.
- Output index: element (i,j) is linear index n = i*d3 + j.
- Grouping: G = ceil(d1*d3 / NUM_MAC). In group g, lane L computes n = g*NUM_MAC + L.
  - A lane with n >= d1*d3 is disabled: it accumulates nothing and writes nothing.
- States: IDLE, MAC, WRITE, DONE.
- IDLE or DONE with start=1, at edge 0:
  - Latch matA and matB into internal operand registers.
  - Clear sat_flag, accumulators, k and g.
  - busy<=1, done<=0; go to MAC.
- MAC (exactly d2 cycles, k = 0..d2-1):
  - Each active lane adds the full 2*BIT_WIDTH-bit product A[i][k]*B[k][j] to its accumulator.
  - Accumulator width: ACC_W = 2*BIT_WIDTH + clog2(d2); it never overflows.
  - After k = d2-1, go to WRITE.
- WRITE (1 cycle), per active lane:
  - Arithmetic right shift of the accumulator by FRACTION_WIDTH (truncation toward negative infinity).
  - Saturate to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1]; if clamped, set sat_flag.
  - Write the value to result[i][j] and clear the accumulator.
  - Then: if g < G-1, increment g and go to MAC; otherwise busy<=0, done<=1, go to DONE.
- Latency: done rises exactly G*(d2+1) cycles after the start edge.
  - Defaults: G=5, latency 30 cycles.
- Result elements update group by group during a run; they are guaranteed valid only while done=1.
- Elements not yet rewritten keep their previous values.
- start during MAC or WRITE is ignored; no queuing.
- Input changes after the start edge have no effect on the run.
- start in DONE restarts immediately; done falls on that edge.

Optional Feature:
- Macro MATMUL_SEQ_RELU_EN.
- Defined: WRITE applies ReLU after saturation, so negative results are written as 0.
  - Negative clamping does not set sat_flag; only positive saturation does.
- Undefined: signed results are written unchanged; no ReLU logic is synthesised.

Decomposition:
- Shared package matmul_pkg holds:
  - State enum typedef.
  - ACC_W computation function.
  - Saturate/shift function sat_q(acc, FRACTION_WIDTH, BIT_WIDTH), which returns the value and an overflow bit.
- Sub-module mac_lane: one signed multiplier plus accumulator with clear, enable and ACC_W width; instantiated NUM_MAC times.
- Operand registers, index counters, FSM and write-back stay in matmul_seq.

Test Plan:
Common setup: FRACTION_WIDTH=8, BIT_WIDTH=16, d1=2, d2=3, d3=2, NUM_MAC=2, so G=2. Values are Q8 (1.0 = 256).
- Basic: A=[[1,2,3],[4,5,6]], B=[[1,0],[0,1],[1,1]] -> result=[[1024,1280],[2560,2816]]; done high 8 cycles after the start edge; sat_flag=0.
- Saturation/sign: all A=0x7FFF, all B=0x7FFF -> every result 0x7FFF, sat_flag=1. Then A=all -1.0 (0xFF00), B=all 1.0 -> every result 0xFD00 (-3.0), sat_flag cleared.
- Partial group: NUM_MAC=3 with the Basic data -> same results; lanes 1-2 disabled in g=1; latency 8; unused lanes write nothing.
- Handshake: pulse start at cycle 3 of a run with different data -> ignored; results match the first data. start in DONE -> done drops next edge; new run completes.
- Reset: assert rst_n=0 at cycle 5 of a run -> result all 0, busy=0, done=0, sat_flag=0 immediately. A new start after release runs normally.
- MATMUL_SEQ_RELU_EN defined: A=all -1.0, B=all 1.0 -> all results 0, sat_flag=0.
